// File: rtl/br_resolve_sched_pkg.sv
// Shared branch package: mask widths, resolution states and record type.
// Used by the resolution scheduler and the branch mask controller.
package br_resolve_sched_pkg;

  localparam int BR_MASK_W  = 5;
  localparam int BR_STATE_W = 2;

  typedef enum logic [BR_STATE_W-1:0] {
    BR_NONE       = 2'd0,
    BR_PR_CORRECT = 2'd1,
    BR_PR_WRONG   = 2'd2
  } br_state_e;

  typedef logic [BR_MASK_W-1:0] br_mask_t;

  typedef struct packed {
    br_mask_t br_bit;
    br_mask_t dep_mask;
    logic     wrong;
  } br_res_t;

endpackage

// File: rtl/br_resolve_sched_if.sv
// Resolution request bus from the branch units and issue bus
// towards the branch mask controller.
interface br_resolve_sched_if
  import br_resolve_sched_pkg::*;
#(
  parameter int N_REQ = 2
);

  logic     [N_REQ-1:0] req_valid_i;
  logic     [N_REQ-1:0] req_ready_o;
  br_mask_t [N_REQ-1:0] req_bit_i;
  br_mask_t [N_REQ-1:0] req_dep_mask_i;
  logic     [N_REQ-1:0] req_wrong_i;

  br_state_e br_state_o;
  br_mask_t  br_dep_mask_o;
  br_mask_t  br_bit_o;
  logic      disp_stall_o;

  modport master (
    output req_valid_i,
    input  req_ready_o,
    output req_bit_i,
    output req_dep_mask_i,
    output req_wrong_i,
    input  br_state_o,
    input  br_dep_mask_o,
    input  br_bit_o,
    input  disp_stall_o
  );

  modport slave (
    input  req_valid_i,
    output req_ready_o,
    input  req_bit_i,
    input  req_dep_mask_i,
    input  req_wrong_i,
    output br_state_o,
    output br_dep_mask_o,
    output br_bit_o,
    output disp_stall_o
  );

endinterface

// File: rtl/br_oldest_sel.sv
// Picks the oldest mispredict by dependency mask, else queue head.
// Pure combinational; result is one-hot or zero.
module br_oldest_sel
  import br_resolve_sched_pkg::*;
#(
  parameter int Q_DEPTH = 4
) (
  input  logic     [Q_DEPTH-1:0] valid_i,
  input  logic     [Q_DEPTH-1:0] wrong_i,
  input  br_mask_t [Q_DEPTH-1:0] bit_i,
  input  br_mask_t [Q_DEPTH-1:0] dep_i,
  output logic     [Q_DEPTH-1:0] sel_o,
  output logic                   any_wrong_o
);

  logic [Q_DEPTH-1:0] cand;
  logic [Q_DEPTH-1:0] root;
  logic [Q_DEPTH-1:0] pool;

  // a wrong entry is a root when it depends on no other wrong entry
  always_comb begin
    cand = valid_i & wrong_i;
    root = '0;
    for (int i = 0; i < Q_DEPTH; i++) begin
      root[i] = cand[i];
      for (int j = 0; j < Q_DEPTH; j++) begin
        if (j != i && cand[j] && |(bit_i[j] & dep_i[i]))
          root[i] = 1'b0;
      end
    end
  end

  // lowest-index root wins; inconsistent masks fall back to any wrong
  always_comb begin
    any_wrong_o = |cand;
    pool        = (|root) ? root : cand;
    sel_o       = '0;
    if (any_wrong_o)
      sel_o = pool & (~pool + Q_DEPTH'(1));
    else
      sel_o[0] = valid_i[0];
  end

endmodule

// File: rtl/br_resolve_sched.sv
// Branch resolution scheduler: age-ordered queue, one issue per cycle,
// mispredicts first, with squash and correct-bit clearing.
module br_resolve_sched
  import br_resolve_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int Q_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  br_resolve_sched_if.slave bus
);

  localparam int CW = $clog2(Q_DEPTH + 1);
  localparam int IW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

  br_res_t [Q_DEPTH-1:0] q_q, q_d;
  logic    [CW-1:0]      cnt_q, cnt_d;

  br_state_e st_q, st_d;
  br_mask_t  dep_q, dep_d;
  br_mask_t  bit_q, bit_d;
  logic      stall_q, stall_d;

  logic     [Q_DEPTH-1:0] vld;
  logic     [Q_DEPTH-1:0] wrg;
  br_mask_t [Q_DEPTH-1:0] qbit;
  br_mask_t [Q_DEPTH-1:0] qdep;
  logic     [Q_DEPTH-1:0] sel;
  logic                   any_wrong;
  logic                   is_corr;
  logic     [N_REQ-1:0]   rdy;

  br_mask_t sel_bit, sel_dep;
  br_mask_t kill_b, clr_b;
  br_mask_t post_kill, post_clr;

  // ready reflects free slots only, never same-cycle activity
  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      rdy[i] = (Q_DEPTH - int'(cnt_q)) > i;
  end

  // unpack the queue for the selector
  always_comb begin
    for (int i = 0; i < Q_DEPTH; i++) begin
      vld[i]  = i < int'(cnt_q);
      wrg[i]  = q_q[i].wrong;
      qbit[i] = q_q[i].br_bit;
      qdep[i] = q_q[i].dep_mask;
    end
  end

  br_oldest_sel #(
    .Q_DEPTH (Q_DEPTH)
  ) u_sel (
    .valid_i     (vld),
    .wrong_i     (wrg),
    .bit_i       (qbit),
    .dep_i       (qdep),
    .sel_o       (sel),
    .any_wrong_o (any_wrong)
  );

  // mux out the selected entry and derive squash/clear masks
  always_comb begin
    sel_bit = '0;
    sel_dep = '0;
    for (int i = 0; i < Q_DEPTH; i++) begin
      if (sel[i]) begin
        sel_bit = sel_bit | qbit[i];
        sel_dep = sel_dep | qdep[i];
      end
    end
    is_corr   = !any_wrong && vld[0];
    kill_b    = any_wrong ? sel_bit : '0;
    clr_b     = is_corr ? sel_bit : '0;
    post_kill = (st_q == BR_PR_WRONG) ? bit_q : '0;
    post_clr  = (st_q == BR_PR_CORRECT) ? bit_q : '0;
    if (any_wrong)
      st_d = BR_PR_WRONG;
    else if (is_corr)
      st_d = BR_PR_CORRECT;
    else
      st_d = BR_NONE;
    bit_d   = sel_bit;
    dep_d   = sel_dep;
    stall_d = any_wrong;
  end

  // remove, squash and clear, compact, then append arrivals in order
  always_comb begin
    br_res_t  e;
    br_mask_t d;
    int       n;
    q_d = '0;
    n   = 0;
    e   = '0;
    d   = '0;
    for (int i = 0; i < Q_DEPTH; i++) begin
      if (vld[i] && !sel[i] && !(|(q_q[i].dep_mask & kill_b))) begin
        e          = q_q[i];
        e.dep_mask = e.dep_mask & ~clr_b;
        q_d[IW'(n)] = e;
        n++;
      end
    end
    for (int r = 0; r < N_REQ; r++) begin
      d = bus.req_dep_mask_i[r];
      if (bus.req_valid_i[r] && rdy[r] && n < Q_DEPTH &&
          !(|(d & kill_b)) && !(|(d & post_kill))) begin
        e.br_bit   = bus.req_bit_i[r];
        e.dep_mask = d & ~clr_b & ~post_clr;
        e.wrong    = bus.req_wrong_i[r];
        q_d[IW'(n)] = e;
        n++;
      end
    end
    cnt_d = CW'(n);
  end

  // queue and issue registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      cnt_q   <= '0;
      st_q    <= BR_NONE;
      dep_q   <= '0;
      bit_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      dep_q   <= dep_d;
      bit_q   <= bit_d;
      stall_q <= stall_d;
    end
  end

  assign bus.req_ready_o   = rdy;
  assign bus.br_state_o    = st_q;
  assign bus.br_dep_mask_o = dep_q;
  assign bus.br_bit_o      = bit_q;
  assign bus.disp_stall_o  = stall_q;

endmodule

// File: tb/tb_br_resolve_sched.sv
// Bench for br_resolve_sched: directed table, corner sequences and
// random traffic against a queue-based reference model.
module tb_br_resolve_sched;
  import br_resolve_sched_pkg::*;

  localparam int NR = 2;
  localparam int QD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  br_resolve_sched_if #(.N_REQ(NR)) bus ();

  br_resolve_sched #(
    .N_REQ   (NR),
    .Q_DEPTH (QD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    br_mask_t b;
    br_mask_t d;
    logic     w;
  } ent_t;

  typedef struct {
    logic [1:0] v;
    br_mask_t   b0, d0;
    logic       w0;
    br_mask_t   b1, d1;
    logic       w1;
    br_state_e  st;
    br_mask_t   eb, ed;
    logic       es;
  } vec_t;

  int total = 0;
  int bad = 0;

  ent_t      mq[$];
  br_state_e m_state = BR_NONE;
  br_mask_t  m_bit = '0;
  br_mask_t  m_dep = '0;

  vec_t tbl[19];

  function automatic vec_t mk(
    input logic [1:0] v,
    input br_mask_t b0, input br_mask_t d0, input logic w0,
    input br_mask_t b1, input br_mask_t d1, input logic w1,
    input br_state_e st, input br_mask_t eb, input br_mask_t ed);
    vec_t t;
    t.v = v;
    t.b0 = b0; t.d0 = d0; t.w0 = w0;
    t.b1 = b1; t.d1 = d1; t.w1 = w1;
    t.st = st; t.eb = eb; t.ed = ed;
    t.es = (st == BR_PR_WRONG);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v,
                       input br_mask_t b0, input br_mask_t d0, input logic w0,
                       input br_mask_t b1, input br_mask_t d1, input logic w1);
    bus.req_valid_i       = v;
    bus.req_bit_i[0]      = b0;
    bus.req_dep_mask_i[0] = d0;
    bus.req_wrong_i[0]    = w0;
    bus.req_bit_i[1]      = b1;
    bus.req_dep_mask_i[1] = d1;
    bus.req_wrong_i[1]    = w1;
  endtask

  task automatic check_model();
    logic [NR-1:0] er;
    for (int r = 0; r < NR; r++)
      er[r] = (QD - mq.size()) > r;
    chk("ready", 32'(bus.req_ready_o), 32'(er));
    chk("state", 32'(bus.br_state_o), 32'(m_state));
    chk("bit", 32'(bus.br_bit_o), 32'(m_bit));
    chk("dep", 32'(bus.br_dep_mask_o), 32'(m_dep));
    chk("stall", 32'(bus.disp_stall_o), 32'(m_state == BR_PR_WRONG));
  endtask

  // reference: oldest mispredict first, else oldest; squash/clear rules
  task automatic model_step();
    int        sel;
    int        room;
    bit        anyw;
    bit        blocked;
    br_mask_t  b, d, din;
    br_state_e ns;
    ent_t      e;
    ent_t      nq[$];
    room = QD - mq.size();
    sel  = -1;
    anyw = 0;
    foreach (mq[i]) begin
      if (mq[i].w) begin
        anyw = 1;
        blocked = 0;
        foreach (mq[j])
          if (j != i && mq[j].w && (mq[j].b & mq[i].d) != 0) blocked = 1;
        if (!blocked && sel < 0) sel = i;
      end
    end
    if (anyw && sel < 0)
      foreach (mq[i]) if (mq[i].w && sel < 0) sel = i;
    if (!anyw && mq.size() > 0) sel = 0;
    ns = (sel < 0) ? BR_NONE : (anyw ? BR_PR_WRONG : BR_PR_CORRECT);
    b  = (sel < 0) ? '0 : mq[sel].b;
    d  = (sel < 0) ? '0 : mq[sel].d;
    foreach (mq[i]) begin
      if (i == sel) continue;
      e = mq[i];
      if (ns == BR_PR_WRONG && (e.d & b) != 0) continue;
      if (ns == BR_PR_CORRECT) e.d = e.d & ~b;
      nq.push_back(e);
    end
    for (int r = 0; r < NR; r++) begin
      if (bus.req_valid_i[r] && room > r) begin
        din = bus.req_dep_mask_i[r];
        if (ns == BR_PR_WRONG && (din & b) != 0) continue;
        if (m_state == BR_PR_WRONG && (din & m_bit) != 0) continue;
        e.b = bus.req_bit_i[r];
        e.w = bus.req_wrong_i[r];
        e.d = din;
        if (ns == BR_PR_CORRECT) e.d = e.d & ~b;
        if (m_state == BR_PR_CORRECT) e.d = e.d & ~m_bit;
        nq.push_back(e);
      end
    end
    mq      = nq;
    m_state = ns;
    m_bit   = b;
    m_dep   = d;
  endtask

  task automatic tick();
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(2'b00, '0, '0, 1'b0, '0, '0, 1'b0);
      tick();
    end
  endtask

  initial begin
    tbl[0]  = mk(2'b01, 5'b00001, 5'b00000, 1'b0, '0, '0, 1'b0, BR_NONE, '0, '0);
    tbl[1]  = mk(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, BR_NONE, '0, '0);
    tbl[2]  = mk(2'b00, '0, '0, 1'b0, '0, '0, 1'b0,
                 BR_PR_CORRECT, 5'b00001, 5'b00000);
    tbl[3]  = mk(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, BR_NONE, '0, '0);
    tbl[4]  = mk(2'b11, 5'b00001, 5'b00000, 1'b0, 5'b00010, 5'b00001, 1'b1,
                 BR_NONE, '0, '0);
    tbl[5]  = mk(2'b01, 5'b00100, 5'b00011, 1'b1, '0, '0, 1'b0, BR_NONE, '0, '0);
    tbl[6]  = mk(2'b00, '0, '0, 1'b0, '0, '0, 1'b0,
                 BR_PR_WRONG, 5'b00010, 5'b00001);
    tbl[7]  = mk(2'b00, '0, '0, 1'b0, '0, '0, 1'b0,
                 BR_PR_CORRECT, 5'b00001, 5'b00000);
    tbl[8]  = mk(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, BR_NONE, '0, '0);
    tbl[9]  = mk(2'b11, 5'b00001, 5'b00000, 1'b0, 5'b00010, 5'b00001, 1'b0,
                 BR_NONE, '0, '0);
    tbl[10] = mk(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, BR_NONE, '0, '0);
    tbl[11] = mk(2'b01, 5'b00100, 5'b00001, 1'b0, '0, '0, 1'b0,
                 BR_PR_CORRECT, 5'b00001, 5'b00000);
    tbl[12] = mk(2'b00, '0, '0, 1'b0, '0, '0, 1'b0,
                 BR_PR_CORRECT, 5'b00010, 5'b00000);
    tbl[13] = mk(2'b00, '0, '0, 1'b0, '0, '0, 1'b0,
                 BR_PR_CORRECT, 5'b00100, 5'b00000);
    tbl[14] = mk(2'b01, 5'b00010, 5'b00000, 1'b1, '0, '0, 1'b0, BR_NONE, '0, '0);
    tbl[15] = mk(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, BR_NONE, '0, '0);
    tbl[16] = mk(2'b10, '0, '0, 1'b0, 5'b01000, 5'b00011, 1'b0,
                 BR_PR_WRONG, 5'b00010, 5'b00000);
    tbl[17] = mk(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, BR_NONE, '0, '0);
    tbl[18] = mk(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, BR_NONE, '0, '0);

    drive(2'b00, '0, '0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready_o), 32'h3);
    chk("rst_state", 32'(bus.br_state_o), 32'(BR_NONE));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].b0, tbl[i].d0, tbl[i].w0,
            tbl[i].b1, tbl[i].d1, tbl[i].w1);
      chk($sformatf("row%0d_state", i), 32'(bus.br_state_o), 32'(tbl[i].st));
      chk($sformatf("row%0d_bit", i), 32'(bus.br_bit_o), 32'(tbl[i].eb));
      chk($sformatf("row%0d_dep", i), 32'(bus.br_dep_mask_o), 32'(tbl[i].ed));
      chk($sformatf("row%0d_stall", i), 32'(bus.disp_stall_o), 32'(tbl[i].es));
      tick();
    end

    for (int k = 0; k < 5; k++) begin
      drive(2'b11, 5'b00001 << (k % 5), '0, 1'b0,
            5'b00001 << ((k + 2) % 5), '0, 1'b0);
      if (k == 2) chk("bp_ready_3", 32'(bus.req_ready_o), 32'h1);
      tick();
    end
    drive(2'b00, '0, '0, 1'b0, '0, '0, 1'b0);
    chk("bp_ready_hold", 32'(bus.req_ready_o), 32'h1);
    tick();
    idle(5);

    for (int k = 0; k < 400; k++) begin
      br_mask_t b0, b1, d0, d1;
      b0 = 5'b00001 << $urandom_range(0, 4);
      b1 = 5'b00001 << $urandom_range(0, 4);
      d0 = br_mask_t'($urandom) & ~b0;
      d1 = br_mask_t'($urandom) & ~b1;
      drive(2'($urandom_range(0, 3)), b0, d0, ($urandom_range(0, 3) == 0),
            b1, d1, ($urandom_range(0, 3) == 0));
      tick();
    end
    idle(6);

    drive(2'b11, 5'b00001, '0, 1'b0, 5'b00010, '0, 1'b0);
    tick();
    drive(2'b11, 5'b00100, '0, 1'b0, 5'b01000, '0, 1'b0);
    tick();
    drive(2'b00, '0, '0, 1'b0, '0, '0, 1'b0);
    chk("pre_rst_ready", 32'(bus.req_ready_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(bus.br_state_o), 32'(BR_NONE));
    chk("arst_bit", 32'(bus.br_bit_o), 32'h0);
    chk("arst_dep", 32'(bus.br_dep_mask_o), 32'h0);
    chk("arst_stall", 32'(bus.disp_stall_o), 32'h0);
    mq.delete();
    m_state = BR_NONE;
    m_bit   = '0;
    m_dep   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(bus.req_ready_o), 32'h3);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
